// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-deep valid/ready holding register.
// Samples mid-bit from a half-bit offset after the start edge and reports
// framing errors and overruns as single-cycle pulses.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV);

    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    sh;
    logic          rx_m;
    logic          rx_s;
    logic          stop_tick;
    logic          deliver;
    logic          bad_stop;

    // Two-flop synchronizer on the asynchronous serial line, idle-high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Stop-bit sample outcome, shared by the FSM and the output register
    always_comb begin
        stop_tick = (state == S_STOP) && (cnt == '0);
        deliver   = stop_tick && rx_s;
        bad_stop  = stop_tick && !rx_s;
    end

    // Frame FSM: start qualification, mid-bit data sampling, stop check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            sh    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= HALF_LOAD;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s) begin
                        cnt   <= FULL_LOAD;
                        bitn  <= '0;
                        state <= S_DATA;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        sh   <= {rx_s, sh[7:1]};
                        cnt  <= FULL_LOAD;
                        bitn <= bitn + 3'd1;
                        if (bitn == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Leave at mid-stop-bit so a gapless next start edge is seen in IDLE
                        state <= rx_s ? S_IDLE : S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Holding register with valid/ready handshake and status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!valid || ready) begin
                    data  <= sh;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    // Busy flag follows the FSM leaving IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else begin
            busy <= 1'b0;
            case (state)
                S_IDLE:  busy <= !rx_s;
                S_START: busy <= (cnt != '0) || !rx_s;
                S_STOP:  busy <= (cnt != '0) || !rx_s;
                default: busy <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at DIV=10.
module tb_uart_rx;

    localparam int DIV = 10;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         n_checks;
    int         n_pass;
    int         cyc;
    int         fe_cnt;
    int         ov_cnt;
    int         beats;
    int         rise_cyc;
    int         start_cyc;
    logic       prev_valid;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (valid && !prev_valid) rise_cyc = cyc;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (valid && ready) begin
                beats++;
                if (exp_q.size() == 0) check("unexpected_beat", {24'h0, data}, 32'hFFFF_FFFF);
                else check("beat_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
            end
        end
        prev_valid = valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(DIV);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        int lat;
        int b0;
        int fe0;
        n_checks = 0; n_pass = 0; cyc = 0;
        fe_cnt = 0; ov_cnt = 0; beats = 0; rise_cyc = 0; start_cyc = 0;
        prev_valid = 1'b0;
        rx = 1'b1; ready = 1'b1; reset_n = 1'b0;
        tick(3);
        check_reset_values("reset");
        reset_n = 1'b1;
        tick(5);

        // Single byte and latency from the start edge
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        drain("single_drain", 30);
        lat = rise_cyc - start_cyc;
        check("single_latency_in_98pm2", (lat >= 96 && lat <= 100), 1);
        check("single_ferr", fe_cnt, 0);
        check("single_ovr", ov_cnt, 0);
        tick(20);

        // Back-to-back frames, no idle gap
        b0 = beats;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        drain("b2b_drain", 30);
        check("b2b_beats", beats - b0, 3);
        tick(20);

        // Glitch rejection
        b0 = beats;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        n = 0;
        while (busy && n < 8) begin
            tick(1);
            n++;
        end
        check("glitch_busy", busy, 0);
        tick(20);
        check("glitch_no_beat", beats - b0, 0);

        // Framing error followed by a break, then a good byte
        fe0 = fe_cnt;
        b0 = beats;
        send_byte(8'h3C, 1'b0);
        rx = 1'b0;
        tick(50);
        check("break_ferr_once", fe_cnt - fe0, 1);
        check("break_no_beat", beats - b0, 0);
        rx = 1'b1;
        tick(20);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        drain("after_break_drain", 30);
        check("after_break_ferr", fe_cnt - fe0, 1);
        tick(20);

        // Overrun with the consumer stalled
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(20);
        check("ovr_pulse_once", ov_cnt, 1);
        check("ovr_valid_held", valid, 1);
        check("ovr_data_kept", data, 8'h11);
        b0 = beats;
        ready = 1'b1;
        drain("ovr_drain", 5);
        tick(3);
        check("ovr_one_beat", beats - b0, 1);
        check("ovr_valid_drop", valid, 0);
        tick(10);

        // Reset in the middle of a frame
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'hC3 >> i) & 8'h01) != 0);
        reset_n = 1'b0;
        rx = 1'b1;
        #1;
        check_reset_values("midreset");
        tick(3);
        reset_n = 1'b1;
        tick(20);
        b0 = beats;
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        drain("midreset_drain", 30);
        tick(20);
        check("midreset_beats", beats - b0, 1);
        check("final_ferr_total", fe_cnt, 1);
        check("final_ovr_total", ov_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Synthesizable UART receiver that deserializes the 8N1 serial line driven by the host (or by the bench's UART transmit model) into bytes for the theremin control logic. It sits directly downstream of the TX pin. It presents each received byte through a one-deep valid/ready holding register, and flags framing errors and overruns.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bits/s. `DIV = CLK_FREQ / BAUD_RATE` (integer division, truncated). `DIV` must be at least 4.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `reset_n` input, 1 bit: reset, asynchronous assert, active-low.
- `rx` input, 1 bit: asynchronous serial line. Idle is high.
- `data` output, 8 bits: received byte. Valid while `valid` is 1.
- `valid` output, 1 bit: the holding register contains an unread byte.
- `ready` input, 1 bit: consumer accepts `data` on any cycle where `valid && ready`.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `overrun` output, 1 bit: one-cycle pulse when a good byte is dropped because the holding register is full.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer to give `rx_s`. The synchronizer resets to 1. All decisions use `rx_s`.
- **Divider:** a down-counter `cnt` of width `$clog2(DIV)`. A bit counter `bitn` of 3 bits.
- **States:**
  - IDLE: on `rx_s == 0`, load `cnt = DIV/2 - 1` and go to START.
  - START: when `cnt == 0`, check `rx_s`.
    - `rx_s == 0`: load `cnt = DIV - 1`, set `bitn = 0`, go to DATA.
    - `rx_s == 1`: glitch; return to IDLE with no output.
  - DATA: when `cnt == 0`, shift `rx_s` into the shift register LSB-first (`sh <= {rx_s, sh[7:1]}`), reload `cnt = DIV - 1`, and increment `bitn`. After the 8th bit (`bitn == 7`), go to STOP.
  - STOP: when `cnt == 0`, check `rx_s`.
    - `rx_s == 1`: good frame; deliver `sh` (rules below) and go to IDLE.
    - `rx_s == 0`: pulse `frame_err`, discard `sh`, go to WAIT_HIGH.
  - WAIT_HIGH: remain until `rx_s == 1`, then go to IDLE. This prevents a break condition from producing repeated frames.
- **Leaving STOP mid-bit:** STOP returns to IDLE at the middle of the stop bit. Back-to-back frames with no gap are received correctly, because IDLE sees the remaining high half-bit before the next start edge.
- **Delivery on a good frame** (`v` is `valid` before the edge, `r` is `ready` on the same cycle):
  - `!v`: load `data = sh`, `valid = 1`.
  - `v && r`: old byte consumed, new byte loaded, `valid` stays 1, no overrun.
  - `v && !r`: keep the old byte, drop the new one, pulse `overrun`.
- **Consume:** on `valid && ready` with no delivery in that cycle, `valid` clears on the next edge.
- **Reset:** `reset_n` low at any time, including mid-frame, forces the following. After release the block waits for a fresh falling edge.
  - State = IDLE.
  - `cnt = 0`, `bitn = 0`, `sh = 0`.
  - `data = 8'h00`.
  - `valid = 0`, `frame_err = 0`, `overrun = 0`, `busy = 0`.
  - Synchronizer FFs = 1.

## Timing
- Synchronizer latency: 2 clocks from the `rx` edge to `rx_s`.
- Start bit is sampled `DIV/2` clocks after the falling edge is seen in IDLE. Each data bit and the stop bit are sampled `DIV` clocks after the previous sample (mid-bit).
- `valid` rises on the edge after the stop-bit sample. That is about `9.5*DIV + 3` clocks after the `rx` start edge.
- `frame_err` and `overrun` are high for exactly one clock, on that same edge.
- `busy` rises one clock after IDLE detects the start. It falls on the edge that returns to IDLE.
- `data` is stable while `valid` is 1. It changes only on a load.
- Supported baud error: ±3% at `DIV >= 16`.

## Test plan
All scenarios use `CLK_FREQ=1_000_000`, `BAUD_RATE=100_000` (`DIV=10`), `ready=1` unless stated.
- **Single byte:** reset, then send byte 0xA5 → `valid` pulses with `data=8'hA5` 98±2 clocks after the start edge; `frame_err=0`, `overrun=0`.
- **Back-to-back, no idle gap:** send 0x00, 0xFF, 0x55 → three `valid` beats carrying 0x00, 0xFF, 0x55 in order, none lost.
- **Glitch rejection:** drive `rx` low for 3 clocks, then high → no `valid`; `busy` returns to 0 within 8 clocks.
- **Framing error then break:** send 0x3C with the stop bit held low, then keep `rx` low for 50 clocks, then send 0x81 → `frame_err` pulses once, no `valid` for 0x3C, then `valid` with `data=8'h81`.
- **Overrun:** hold `ready=0`, send 0x11 then 0x22 → `data` stays 0x11, `overrun` pulses once at the end of the second frame. Then raise `ready` → one beat of 0x11, after which `valid` drops.
- **Reset mid-frame:** pulse `reset_n` low after 4 data bits of 0xC3, then send 0x5A → all outputs at their reset values during reset; the next `valid` carries 0x5A only.
